// File: rtl/alu_exec_stage_pkg.sv
// Shared ALU definitions: opcode width, opcode constants, stage state and flag bundle.
package alu_exec_stage_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD       = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD_CARRY = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB       = 4'd3;
  localparam logic [OP_W-1:0] OP_INC       = 4'd4;
  localparam logic [OP_W-1:0] OP_DEC       = 4'd5;
  localparam logic [OP_W-1:0] OP_AND       = 4'd6;
  localparam logic [OP_W-1:0] OP_NOT       = 4'd7;
  localparam logic [OP_W-1:0] OP_ROL       = 4'd8;
  localparam logic [OP_W-1:0] OP_ROR       = 4'd9;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic carry;
    logic borrow;
    logic zero;
    logic parity;
    logic invalid;
  } alu_flags_t;

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational team ALU. Carry comes from ADD/ADD_CARRY/INC, borrow from SUB/DEC;
// parity is the XOR of all result bits (1 = odd number of ones).
module alu_exec_stage_alu
  import alu_exec_stage_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic [OP_W-1:0]      opcode,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BUS_WIDTH-1:0] y,
  output alu_flags_t           flags
);

  localparam logic [BUS_WIDTH:0] ONE = {{BUS_WIDTH{1'b0}}, 1'b1};

  logic [BUS_WIDTH:0] wide_a;
  logic [BUS_WIDTH:0] wide_b;
  logic [BUS_WIDTH:0] wide_cin;

  assign wide_a   = {1'b0, a};
  assign wide_b   = {1'b0, b};
  assign wide_cin = {{BUS_WIDTH{1'b0}}, carry_in};

  always_comb begin
    y             = '0;
    flags.carry   = 1'b0;
    flags.borrow  = 1'b0;
    flags.invalid = 1'b0;
    case (opcode)
      OP_ADD:       {flags.carry, y}  = wide_a + wide_b;
      OP_ADD_CARRY: {flags.carry, y}  = wide_a + wide_b + wide_cin;
      OP_SUB:       {flags.borrow, y} = wide_a - wide_b;
      OP_INC:       {flags.carry, y}  = wide_a + ONE;
      OP_DEC:       {flags.borrow, y} = wide_a - ONE;
      OP_AND:       y = a & b;
      OP_NOT:       y = ~a;
      OP_ROL:       y = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
      OP_ROR:       y = {a[0], a[BUS_WIDTH-1:1]};
      default:      flags.invalid = 1'b1;
    endcase
    flags.zero   = (y == '0);
    flags.parity = ^y;
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: one-entry output register with valid/ready on both sides,
// a carry-chain flag for ADD_CARRY/INC, and a saturating invalid-opcode counter.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_opcode,
  input  logic [BUS_WIDTH-1:0] in_a,
  input  logic [BUS_WIDTH-1:0] in_b,
  input  logic                 clear_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_y,
  output logic                 out_carry,
  output logic                 out_borrow,
  output logic                 out_zero,
  output logic                 out_parity,
  output logic                 out_invalid,
  output logic                 carry_flag,
  output logic [7:0]           invalid_count,
  output state_t               dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // The producer holds its payload stable while valid && !ready; ready never waits on valid.

  state_t                 state_q, state_d;
  logic                   accept;
  logic [BUS_WIDTH-1:0]   alu_y;
  alu_flags_t             alu_flags;
  alu_flags_t             flags_q;

  alu_exec_stage_alu #(.BUS_WIDTH(BUS_WIDTH)) alu (
    .opcode   (in_opcode),
    .a        (in_a),
    .b        (in_b),
    .carry_in (carry_flag),
    .y        (alu_y),
    .flags    (alu_flags)
  );

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_FULL);
    in_ready  = (state_q == ST_EMPTY) || out_ready;
    dbg_state = state_q;
  end

  // The result register only loads on acceptance, so a stalled result stays put.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_y   <= '0;
      flags_q <= '0;
    end else if (accept) begin
      out_y   <= alu_y;
      flags_q <= alu_flags;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry_flag <= 1'b0;
    end else if (clear_carry) begin
      carry_flag <= 1'b0;
    end else if (accept && (in_opcode == OP_ADD_CARRY || in_opcode == OP_INC)) begin
      carry_flag <= alu_flags.carry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      invalid_count <= 8'd0;
    end else if (accept && alu_flags.invalid && invalid_count != 8'hFF) begin
      invalid_count <= invalid_count + 8'd1;
    end
  end

  assign out_carry   = flags_q.carry;
  assign out_borrow  = flags_q.borrow;
  assign out_zero    = flags_q.zero;
  assign out_parity  = flags_q.parity;
  assign out_invalid = flags_q.invalid;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios plus random traffic against an
// arithmetic reference model with a one-deep expected-result queue.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  localparam int BW    = 8;
  localparam int EXP_W = BW + 5;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_opcode;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          clear_carry;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_y;
  logic          out_carry, out_borrow, out_zero, out_parity, out_invalid;
  logic          carry_flag;
  logic [7:0]    invalid_count;
  state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  // Model: {invalid, parity, zero, borrow, carry, y}; entry present == result held.
  logic [EXP_W-1:0] exp_q[$];
  logic             m_carry;
  int               m_cnt;

  alu_exec_stage #(.BUS_WIDTH(BW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_a          (in_a),
    .in_b          (in_b),
    .clear_carry   (clear_carry),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_y         (out_y),
    .out_carry     (out_carry),
    .out_borrow    (out_borrow),
    .out_zero      (out_zero),
    .out_parity    (out_parity),
    .out_invalid   (out_invalid),
    .carry_flag    (carry_flag),
    .invalid_count (invalid_count),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] ref_alu(input int op, input int a, input int b, input int cin);
    int y, c, bo, inv, p, d;
    y = 0; c = 0; bo = 0; inv = 0;
    case (op)
      1: begin y = (a + b) % 256; c = (a + b > 255); end
      2: begin y = (a + b + cin) % 256; c = (a + b + cin > 255); end
      3: begin d = a - b; bo = (d < 0); y = (d + 256) % 256; end
      4: begin y = (a + 1) % 256; c = (a == 255); end
      5: begin d = a - 1; bo = (d < 0); y = (d + 256) % 256; end
      6: y = a & b;
      7: y = 255 - a;
      8: y = ((a * 2) % 256) + (a / 128);
      9: y = (a / 2) + ((a % 2) * 128);
      default: inv = 1;
    endcase
    p = 0;
    d = y;
    while (d > 0) begin
      p = p + (d % 2);
      d = d / 2;
    end
    return {inv[0], p[0], (y == 0), bo[0], c[0], y[BW-1:0]};
  endfunction

  // scoreboard: compare DUT against the model before the edge
  task automatic sb_check();
    logic [EXP_W-1:0] e;
    check_eq("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    check_eq("dbg_state", dbg_state, (exp_q.size() != 0) ? ST_FULL : ST_EMPTY);
    check_eq("carry_flag", carry_flag, m_carry);
    check_eq("invalid_count", invalid_count, m_cnt);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check_eq("out_y", out_y, e[BW-1:0]);
      check_eq("out_flags", {out_invalid, out_parity, out_zero, out_borrow, out_carry}, e[EXP_W-1:BW]);
    end
  endtask

  task automatic model_edge();
    logic             acc;
    logic [EXP_W-1:0] r;
    acc = in_valid && ((exp_q.size() == 0) || out_ready);
    r   = ref_alu(int'(in_opcode), int'(in_a), int'(in_b), int'(m_carry));
    if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(r);
      if (r[EXP_W-1] && m_cnt < 255) m_cnt++;
    end
    if (clear_carry) m_carry = 1'b0;
    else if (acc && (in_opcode == 4'd2 || in_opcode == 4'd4)) m_carry = r[BW];
  endtask

  task automatic step();
    @(negedge clk);
    sb_check();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input logic v, input int op, input int a, input int b,
                       input logic ordy, input logic clr);
    in_valid    = v;
    in_opcode   = op[3:0];
    in_a        = a[BW-1:0];
    in_b        = b[BW-1:0];
    out_ready   = ordy;
    clear_carry = clr;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 0, 0, 0, ordy, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_carry = 1'b0;
    m_cnt   = 0;
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    idle(1'b0);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_y", out_y, 0);
    check_eq("rst_flags", {out_invalid, out_parity, out_zero, out_borrow, out_carry}, 0);
    check_eq("rst_count", invalid_count, 0);
    check_eq("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // ADD 9+33
    drive(1'b1, 1, 9, 33, 1'b1, 1'b0); step();
    idle(1'b1);
    check_eq("add_valid", out_valid, 1);
    check_eq("add_y", out_y, 42);
    check_eq("add_zero", out_zero, 0);
    check_eq("add_parity", out_parity, 1);
    step();

    // INC 255 then ADD_CARRY 9+33 consuming the carry
    drive(1'b1, 4, 255, 0, 1'b1, 1'b0); step();
    check_eq("inc_y", out_y, 0);
    check_eq("inc_carry", out_carry, 1);
    check_eq("inc_zero", out_zero, 1);
    check_eq("inc_carry_flag", carry_flag, 1);
    drive(1'b1, 2, 9, 33, 1'b1, 1'b0); step();
    check_eq("adc_y", out_y, 43);
    check_eq("adc_carry_flag", carry_flag, 0);
    idle(1'b1); step();

    // SUB 65-66 held under backpressure, second command stalled, then back-to-back
    drive(1'b1, 3, 65, 66, 1'b0, 1'b0); step();
    drive(1'b1, 1, 1, 2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_eq("sub_hold_y", out_y, 255);
      check_eq("sub_hold_borrow", out_borrow, 1);
      check_eq("stall_in_ready", in_ready, 0);
      step();
    end
    drive(1'b1, 1, 1, 2, 1'b1, 1'b0); step();
    check_eq("b2b_valid", out_valid, 1);
    check_eq("b2b_y", out_y, 3);
    idle(1'b1); step();

    // 260 invalid opcodes, counter saturates
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 0, $urandom_range(255), $urandom_range(255), 1'b1, 1'b0);
      step();
      check_eq("inv_flag", out_invalid, 1);
      check_eq("inv_y", out_y, 0);
    end
    idle(1'b1); step();
    check_eq("inv_count_sat", invalid_count, 255);

    // clear_carry wins over ADD_CARRY update, op still sees carry=1
    drive(1'b1, 4, 255, 0, 1'b1, 1'b0); step();
    drive(1'b1, 2, 1, 1, 1'b1, 1'b1); step();
    check_eq("clr_y", out_y, 3);
    check_eq("clr_carry_flag", carry_flag, 0);
    idle(1'b1); step();

    // random traffic
    for (int i = 0; i < 500; i++) begin
      drive(1'(($urandom_range(3)) != 0), $urandom_range(11), $urandom_range(255),
            $urandom_range(255), 1'(($urandom_range(2)) != 0), 1'($urandom_range(9) == 0));
      step();
    end

    // reset while FULL under backpressure, with carry_flag set
    drive(1'b1, 4, 255, 0, 1'b1, 1'b0); step();
    drive(1'b1, 1, 5, 6, 1'b0, 1'b0); step();
    idle(1'b0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_carry", carry_flag, 0);
    check_eq("mid_rst_count", invalid_count, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    check_eq("post_rst_ready", in_ready, 1);
    step();
    drive(1'b1, 6, 8'hF0, 8'h3C, 1'b1, 1'b0); step();
    idle(1'b1); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
